// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for an RV32 core: instruction fetch port plus a
//   load/store port on a word-organised RAM. Reads are registered (1 cycle).
//   Stores are posted through a one-entry write buffer that is forwarded
//   per byte lane to both read ports. Misaligned stores are dropped, pulse
//   o_misalign for one cycle and set the sticky o_fault flag.
//
//   Optional feature macro: MEMRESP_BOUNDS_EN
//     defined   : addresses with any bit above IDX_W+1 set are out of range;
//                 such stores are dropped, loads return 0, fetches return
//                 RESET_INST, and o_fault is set.
//     undefined : high address bits are ignored (wrap modulo DEPTH_WORDS).
//
// Ports
//   i_clk       clock, all state on posedge
//   i_rst_n     synchronous active-low reset
//   i_pc        fetch byte address          o_inst     fetched word (reg)
//   i_write     store request               i_addr     load/store byte addr
//   i_wdata     right-justified store data  i_memsize  01 byte/10 half/11 word
//   o_rdata     load data >> 8*addr[1:0]    o_misalign misaligned-store pulse
//   o_fault     sticky fault, reset-only clear
module data_mem_responder #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] RESET_INST  = 32'h00000013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_memsize,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  // Overlay the pending buffer's enabled bytes onto an array word.
  function automatic logic [31:0] merge_word(input logic [31:0] arr_word,
                                             input logic        hit,
                                             input logic [3:0]  be,
                                             input logic [31:0] data);
    logic [31:0] m;
    m = arr_word;
    for (int b = 0; b < 4; b++) begin
      if (hit && be[b]) begin
        m[8*b +: 8] = data[8*b +: 8];
      end else begin
        m[8*b +: 8] = m[8*b +: 8];
      end
    end
    return m;
  endfunction

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic             r_wb_valid;
  logic [IDX_W-1:0] r_wb_idx;
  logic [3:0]       r_wb_be;
  logic [31:0]      r_wb_data;
  logic [31:0]      r_inst;
  logic [31:0]      r_rdata;
  logic             r_misalign;
  logic             r_fault;

  logic [IDX_W-1:0] w_ld_idx;
  logic [IDX_W-1:0] w_pc_idx;
  logic [31:0]      w_ld_word;
  logic [31:0]      w_inst_word;
  logic [31:0]      w_ld_shift;
  logic [3:0]       w_st_be;
  logic [31:0]      w_st_data;
  logic             w_st_misalign;
  logic             w_st_req;
  logic             w_st_accept;
  logic             w_addr_oor;
  logic             w_pc_oor;
  logic             w_fault_set;

  assign w_ld_idx = i_addr[IDX_W+1:2];
  assign w_pc_idx = i_pc[IDX_W+1:2];

`ifdef MEMRESP_BOUNDS_EN
  assign w_addr_oor = |i_addr[31:IDX_W+2];
  assign w_pc_oor   = |i_pc[31:IDX_W+2];
  logic w_unused_bits;
  assign w_unused_bits = ^i_pc[1:0];
`else
  assign w_addr_oor = 1'b0;
  assign w_pc_oor   = 1'b0;
  logic w_unused_bits;
  assign w_unused_bits = ^{i_addr[31:IDX_W+2], i_pc[31:IDX_W+2], i_pc[1:0]};
`endif

  // Read-side merge: forwarding uses buffer state from before this edge.
  assign w_ld_word   = merge_word(r_mem[w_ld_idx], r_wb_valid && (r_wb_idx == w_ld_idx),
                                  r_wb_be, r_wb_data);
  assign w_inst_word = merge_word(r_mem[w_pc_idx], r_wb_valid && (r_wb_idx == w_pc_idx),
                                  r_wb_be, r_wb_data);
  assign w_ld_shift  = w_ld_word >> {i_addr[1:0], 3'b000};

  // Store decode: byte enables, lane replication and alignment check.
  always_comb begin
    w_st_be       = 4'b0000;
    w_st_data     = 32'h0000_0000;
    w_st_misalign = 1'b0;
    case (i_memsize)
      2'b01: begin
        w_st_be   = 4'b0001 << i_addr[1:0];
        w_st_data = {4{i_wdata[7:0]}};
      end
      2'b10: begin
        w_st_be       = 4'b0011 << i_addr[1:0];
        w_st_data     = {2{i_wdata[15:0]}};
        w_st_misalign = i_addr[0];
      end
      2'b11: begin
        w_st_be       = 4'b1111;
        w_st_data     = i_wdata;
        w_st_misalign = |i_addr[1:0];
      end
      default: begin
        w_st_be       = 4'b0000;
        w_st_data     = 32'h0000_0000;
        w_st_misalign = 1'b0;
      end
    endcase
  end

  assign w_st_req    = i_write && (i_memsize != 2'b00);
  assign w_st_accept = w_st_req && !w_st_misalign && !w_addr_oor;
  // Loads are issued every cycle, so an out-of-range i_addr faults even
  // without a store; an out-of-range store is covered by the same term.
  assign w_fault_set = (w_st_req && w_st_misalign) || w_addr_oor || w_pc_oor;

  // Buffer capture, registered read data and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_idx   <= '0;
      r_wb_be    <= 4'b0000;
      r_wb_data  <= 32'h0000_0000;
      r_inst     <= RESET_INST;
      r_rdata    <= 32'h0000_0000;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_wb_valid <= w_st_accept;
      if (w_st_accept) begin
        r_wb_idx  <= w_ld_idx;
        r_wb_be   <= w_st_be;
        r_wb_data <= w_st_data;
      end
      r_inst     <= w_pc_oor   ? RESET_INST    : w_inst_word;
      r_rdata    <= w_addr_oor ? 32'h0000_0000 : w_ld_shift;
      r_misalign <= w_st_req && w_st_misalign;
      r_fault    <= r_fault || w_fault_set;
    end
  end

  // Commit the pending entry; a reset on this edge discards it instead.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && r_wb_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wb_be[b]) begin
          r_mem[r_wb_idx][8*b +: 8] <= r_wb_data[8*b +: 8];
        end
      end
    end
  end

  assign o_inst     = r_inst;
  assign o_rdata    = r_rdata;
  assign o_misalign = r_misalign;
  assign o_fault    = r_fault;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: stimulus pushes expected output values tagged with the
// cycle they must appear; a negedge monitor pops and compares them.
module tb_data_mem_responder;

  localparam int SEL_RDATA = 0;
  localparam int SEL_INST  = 1;
  localparam int SEL_MIS   = 2;
  localparam int SEL_FAULT = 3;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_pc;
  logic [31:0] o_inst;
  logic        i_write;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [1:0]  i_memsize;
  logic [31:0] o_rdata;
  logic        o_misalign;
  logic        o_fault;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   total   = 0;
  int   bad     = 0;

  data_mem_responder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_pc       (i_pc),
    .o_inst     (o_inst),
    .i_write    (i_write),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_memsize  (i_memsize),
    .o_rdata    (o_rdata),
    .o_misalign (o_misalign),
    .o_fault    (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SEL_RDATA: act = o_rdata;
        SEL_INST:  act = o_inst;
        SEL_MIS:   act = {31'd0, o_misalign};
        default:   act = {31'd0, o_fault};
      endcase
      total++;
      if (e.cyc != cyc_cnt) begin
        bad++;
        $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cyc_cnt);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.val);
      end
    end
  end

  // Expect a value on the output produced by the cycle about to be issued.
  task automatic expect_out(input int sel, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc);
    i_write   = w;
    i_memsize = sz;
    i_addr    = a;
    i_wdata   = d;
    i_pc      = pc;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [31:0] a, input logic [31:0] pc);
    issue(1'b0, 2'b00, a, 32'h0, pc);
  endtask

  initial begin
    rst_n     = 1'b0;
    i_write   = 1'b0;
    i_memsize = 2'b00;
    i_addr    = 32'h0;
    i_wdata   = 32'h0;
    i_pc      = 32'h0;
    @(posedge clk);
    #2;

    // 1: reset
    idle(32'h0, 32'h0);
    expect_out(SEL_INST,  32'h0000_0013, "rst_inst");
    expect_out(SEL_RDATA, 32'h0,         "rst_rdata");
    expect_out(SEL_FAULT, 32'h0,         "rst_fault");
    expect_out(SEL_MIS,   32'h0,         "rst_mis");
    idle(32'h0, 32'h0);
    rst_n = 1'b1;

    // Background words used later.
    issue(1'b1, 2'b11, 32'h0000_0000, 32'hA5A5_0001, 32'h0);
    issue(1'b1, 2'b11, 32'h0000_0030, 32'h0BAD_CAFE, 32'h0);
    issue(1'b1, 2'b11, 32'h0000_0040, 32'h0000_0000, 32'h0);
    idle(32'h0, 32'h0);

    // 2: store word then forwarded load, then array load with shift
    issue(1'b1, 2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    expect_out(SEL_RDATA, 32'hDEAD_BEEF, "fwd_word");
    idle(32'h0000_0010, 32'h0);
    expect_out(SEL_RDATA, 32'h0000_00DE, "load_shift3");
    idle(32'h0000_0013, 32'h0);

    // 3: byte then half back-to-back over a word
    issue(1'b1, 2'b11, 32'h0000_0020, 32'h1122_3344, 32'h0);
    issue(1'b1, 2'b01, 32'h0000_0021, 32'h0000_00AA, 32'h0);
    issue(1'b1, 2'b10, 32'h0000_0022, 32'h0000_BBCC, 32'h0);
    expect_out(SEL_RDATA, 32'hBBCC_AA44, "merge_load");
    expect_out(SEL_INST,  32'hBBCC_AA44, "merge_fetch");
    idle(32'h0000_0020, 32'h0000_0020);

    // 4: misaligned half and word stores
    expect_out(SEL_MIS,   32'h1, "mis_half_pulse");
    expect_out(SEL_FAULT, 32'h1, "mis_half_fault");
    issue(1'b1, 2'b10, 32'h0000_0031, 32'h0000_FFFF, 32'h0);
    expect_out(SEL_MIS,   32'h0, "mis_half_end");
    expect_out(SEL_FAULT, 32'h1, "fault_sticky");
    expect_out(SEL_RDATA, 32'h0BAD_CAFE, "mis_half_dropped");
    idle(32'h0000_0030, 32'h0);
    expect_out(SEL_MIS, 32'h1, "mis_word_pulse");
    issue(1'b1, 2'b11, 32'h0000_0032, 32'hFFFF_FFFF, 32'h0);
    expect_out(SEL_MIS,   32'h0, "mis_word_end");
    expect_out(SEL_RDATA, 32'h0BAD_CAFE, "mis_word_dropped");
    idle(32'h0000_0030, 32'h0);
    expect_out(SEL_MIS, 32'h0, "size00_nofault");
    issue(1'b1, 2'b00, 32'h0000_0031, 32'hFFFF_FFFF, 32'h0);

    // 5: same-cycle store is not visible, next cycle is
    expect_out(SEL_RDATA, 32'h0, "same_cycle_old");
    issue(1'b1, 2'b01, 32'h0000_0040, 32'h0000_0055, 32'h0);
    expect_out(SEL_RDATA, 32'h0000_0055, "next_cycle_new");
    idle(32'h0000_0040, 32'h0);

    // 6: reset discards the pending write
    issue(1'b1, 2'b11, 32'h0000_0050, 32'hCAFE_F00D, 32'h0);
    idle(32'h0, 32'h0);
    issue(1'b1, 2'b11, 32'h0000_0050, 32'h1234_5678, 32'h0);
    rst_n = 1'b0;
    expect_out(SEL_FAULT, 32'h0, "rst_clears_fault");
    idle(32'h0, 32'h0);
    rst_n = 1'b1;
    idle(32'h0, 32'h0);
    expect_out(SEL_RDATA, 32'hCAFE_F00D, "rst_discard");
    idle(32'h0000_0050, 32'h0);

    // Range behaviour
`ifdef MEMRESP_BOUNDS_EN
    expect_out(SEL_RDATA, 32'h0,         "oor_load");
    expect_out(SEL_INST,  32'h0000_0013, "oor_fetch");
    expect_out(SEL_FAULT, 32'h1,         "oor_fault");
`else
    expect_out(SEL_RDATA, 32'hA5A5_0001, "wrap_load");
    expect_out(SEL_INST,  32'hA5A5_0001, "wrap_fetch");
    expect_out(SEL_FAULT, 32'h0,         "wrap_nofault");
`endif
    idle(32'h0000_4000, 32'h0000_4000);

    idle(32'h0, 32'h0);
    idle(32'h0, 32'h0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
